// File: rtl/ysyx_axi_rd_sched.sv
// ---------------------------------------------------------------------------
// ysyx_axi_rd_sched
//
// Shares one AXI read channel between the instruction fetch unit (IFU) and
// the load/store unit (LSU). Only one read is outstanding at a time. The FSM
// walks IDLE -> ADDR -> DATA -> IDLE. When both units ask at once, the unit
// that was not granted last time wins.
//
// Ports
//   clk, rst                 : clock and asynchronous active-high reset
//   ifu_arvalid/ifu_araddr   : IFU request; held until ifu_rvalid_o
//   ifu_rvalid_o             : one-cycle IFU completion pulse
//   lsu_arvalid/lsu_araddr/
//   lsu_arsize               : LSU request; held until lsu_rvalid_o
//   lsu_rvalid_o             : one-cycle LSU completion pulse
//   rdata_o                  : 32-bit half of the 64-bit beat chosen by
//                              address bit 2; zero outside DATA
//   err_o                    : sticky error (bad rresp or rid mismatch)
//   io_master_ar*            : AXI read-address channel (master side)
//   io_master_r*             : AXI read-data channel (master side)
// ---------------------------------------------------------------------------
module ysyx_axi_rd_sched #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_arvalid,
   input  logic [ADDR_W-1:0] ifu_araddr,
   output logic              ifu_rvalid_o,
   input  logic              lsu_arvalid,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic [2:0]        lsu_arsize,
   output logic              lsu_rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o,
   output logic              io_master_arvalid,
   input  logic              io_master_arready,
   output logic [ADDR_W-1:0] io_master_araddr,
   output logic [2:0]        io_master_arsize,
   output logic [3:0]        io_master_arid,
   input  logic              io_master_rvalid,
   output logic              io_master_rready,
   input  logic [63:0]       io_master_rdata,
   input  logic [1:0]        io_master_rresp,
   input  logic [3:0]        io_master_rid,
   input  logic              io_master_rlast
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [2:0] IFU_SIZE = 3'b010;

   state_t            state;
   state_t            state_next;
   logic              last_lsu;
   logic              owner_lsu;
   logic              abandoned;
   logic              err_q;
   logic [ADDR_W-1:0] lat_addr;
   logic [2:0]        lat_size;

   logic              any_req;
   logic              grant_lsu;
   logic              owner_req;
   logic              beat;
   logic              done;
   logic              deliver;
   logic [3:0]        lat_id;
   logic [31:0]       rdata_half;

   // Arbitration and handshake decode. With both units asking, the LSU wins
   // unless it was the previous owner, which gives strict alternation under
   // continuous contention. A beat counts as accepted whenever rvalid is seen
   // in DATA, because rready is held high for the whole DATA state. The
   // completion pulse is withheld if the owner ever let go of its request,
   // so a unit that gave up never sees stale data handed to it.
   always_comb begin
      any_req    = ifu_arvalid || lsu_arvalid;
      grant_lsu  = lsu_arvalid && (!ifu_arvalid || !last_lsu);
      owner_req  = owner_lsu ? lsu_arvalid : ifu_arvalid;
      beat       = (state == DATA) && io_master_rvalid;
      done       = beat && io_master_rlast;
      deliver    = done && !abandoned && owner_req;
      lat_id     = {3'b000, owner_lsu};
      rdata_half = lat_addr[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
   end

   // State register. Reset drops straight to IDLE, which also kills every
   // output decoded from the state below, so an in-flight transfer is
   // abandoned without any completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode. The address-channel outputs are only
   // driven from the latched request while in ADDR, and read out as zero
   // everywhere else so the bus looks quiet between transfers.
   always_comb begin
      state_next        = state;
      io_master_arvalid = 1'b0;
      io_master_araddr  = '0;
      io_master_arsize  = 3'b000;
      io_master_arid    = 4'h0;
      io_master_rready  = 1'b0;
      ifu_rvalid_o      = 1'b0;
      lsu_rvalid_o      = 1'b0;
      rdata_o           = '0;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_next = ADDR;
            end
         end
         ADDR: begin
            io_master_arvalid = 1'b1;
            io_master_araddr  = lat_addr;
            io_master_arsize  = lat_size;
            io_master_arid    = lat_id;
            if (io_master_arready) begin
               state_next = DATA;
            end
         end
         DATA: begin
            io_master_rready = 1'b1;
            rdata_o          = DATA_W'(rdata_half);
            ifu_rvalid_o     = deliver && !owner_lsu;
            lsu_rvalid_o     = deliver && owner_lsu;
            if (done) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request capture. Owner, address and size are only sampled on the IDLE
   // grant, so requests that show up while a transfer is in flight cannot
   // disturb the values being presented on the bus. The abandoned flag
   // remembers whether the owner released its request at any point during
   // ADDR or DATA.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_lsu  <= 1'b0;
         owner_lsu <= 1'b0;
         lat_addr  <= '0;
         lat_size  <= 3'b000;
         abandoned <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  owner_lsu <= grant_lsu;
                  last_lsu  <= grant_lsu;
                  lat_addr  <= grant_lsu ? lsu_araddr : ifu_araddr;
                  lat_size  <= grant_lsu ? lsu_arsize : IFU_SIZE;
                  abandoned <= 1'b0;
               end
            end
            ADDR, DATA: begin
               if (!owner_req) begin
                  abandoned <= 1'b1;
               end
            end
            default: begin
               abandoned <= abandoned;
            end
         endcase
      end
   end

   // Sticky error flag. Any accepted beat carrying a non-OKAY response or an
   // ID that does not match the one we issued sets it; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (beat && ((io_master_rresp != 2'b00) || (io_master_rid != lat_id))) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;

endmodule

// File: doc/ysyx_axi_rd_sched.md
YSYX_AXI_RD_SCHED -- requirements
Module: ysyx_axi_rd_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 SHALL have parameter DATA_W, default 32, the requester data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port ifu_arvalid, input, 1, IFU read request; held high until ifu_rvalid_o.
REQ-006 SHALL have port ifu_araddr, input, ADDR_W, IFU read address.
REQ-007 SHALL have port ifu_rvalid_o, output, 1, one-cycle IFU completion pulse.
REQ-008 SHALL have port lsu_arvalid, input, 1, LSU read request; held high until lsu_rvalid_o.
REQ-009 SHALL have port lsu_araddr, input, ADDR_W, LSU read address.
REQ-010 SHALL have port lsu_arsize, input, 3, LSU AXI size code.
REQ-011 SHALL have port lsu_rvalid_o, output, 1, one-cycle LSU completion pulse.
REQ-012 SHALL have port rdata_o, output, DATA_W, shared read data for the active owner.
REQ-013 SHALL have port err_o, output, 1, sticky error flag for a nonzero rresp or an rid mismatch.
REQ-014 SHALL have port io_master_arvalid, output, 1, AXI address-read valid.
REQ-015 SHALL have port io_master_arready, input, 1, AXI address-read ready.
REQ-016 SHALL have port io_master_araddr, output, ADDR_W, AXI address-read address.
REQ-017 SHALL have port io_master_arsize, output, 3, AXI address-read size.
REQ-018 SHALL have port io_master_arid, output, 4, AXI address-read ID: 0 for IFU, 1 for LSU.
REQ-019 SHALL have port io_master_rvalid, input, 1, AXI read-data valid.
REQ-020 SHALL have port io_master_rready, output, 1, AXI read-data ready.
REQ-021 SHALL have port io_master_rdata, input, 64, AXI read data.
REQ-022 SHALL have port io_master_rresp, input, 2, AXI read response.
REQ-023 SHALL have port io_master_rid, input, 4, AXI read-data ID.
REQ-024 SHALL have port io_master_rlast, input, 1, AXI read-data last beat.

Function
REQ-025 SHALL implement a three-state FSM with states IDLE, ADDR and DATA, and SHALL keep at most one transaction outstanding.
REQ-026 In IDLE with any request pending, the FSM SHALL latch owner, address and size, then move to ADDR on the next edge.
REQ-027 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; the last-grant register SHALL reset to IFU, so LSU wins the first tie.
REQ-028 The IFU size SHALL be 3'b010; the LSU size SHALL be lsu_arsize as latched at grant.
REQ-029 In ADDR, io_master_arvalid SHALL be 1 and araddr/arsize/arid SHALL come from the latched values, stable until the handshake completes.
REQ-030 ADDR SHALL move to DATA on the edge where io_master_arvalid and io_master_arready are both high.
REQ-031 io_master_rready SHALL be 1 only in DATA.
REQ-032 In DATA, a beat with io_master_rvalid and io_master_rlast SHALL pulse the owner's rvalid_o combinationally in the same cycle, then move to IDLE.
REQ-033 rdata_o SHALL be rdata[63:32] when latched addr[2]=1, else rdata[31:0]; rdata_o SHALL be 0 outside DATA.
REQ-034 A beat with rvalid high and rlast low SHALL be consumed without an rvalid_o pulse.
REQ-035 err_o SHALL set on any accepted beat with rresp!=0 or rid!=latched arid, and SHALL stay set until reset; the completion pulse SHALL still occur.
REQ-036 If the owner drops arvalid mid-transaction, the bus transaction SHALL still complete, rvalid_o SHALL be suppressed, and the FSM SHALL return to IDLE.
REQ-037 Minimum latency SHALL be request in cycle N, arvalid in N+1, DATA in N+2, and completion in N+2 if rvalid and rlast are high then; back-to-back grants resume from IDLE.
REQ-038 A request arriving in ADDR or DATA SHALL wait, and SHALL NOT alter the latched values.

Reset
REQ-039 While rst is high, state SHALL be IDLE and last-grant SHALL be IFU.
REQ-040 While rst is high, io_master_arvalid, io_master_rready, ifu_rvalid_o, lsu_rvalid_o and err_o SHALL be 0, and araddr, arsize, arid and rdata_o SHALL be 0.
REQ-041 Reset asserted mid-transaction SHALL abandon the transaction immediately, and SHALL NOT produce any rvalid_o pulse.

Verification
REQ-042 Single IFU read: ifu_araddr=0x3000_0004, arready at cycle 1, rdata=0xAABBCCDD_11223344 with rlast at cycle 3 -> ifu_rvalid_o=1 and rdata_o=0xAABBCCDD at cycle 3, arid=0, arsize=2.
REQ-043 Contention: IFU and LSU request together after reset -> LSU granted first (arid=1), then IFU, then LSU again while both hold requests.
REQ-044 Delayed arready: arready held low for 5 cycles -> arvalid and araddr stable for 6 cycles, no rready before the handshake.
REQ-045 Error: rresp=2'b10 on the last beat -> rvalid_o pulses, err_o=1 from the next cycle until rst.
REQ-046 Abort: LSU drops arvalid in ADDR -> transaction completes, lsu_rvalid_o stays 0, next IFU request granted from IDLE.
REQ-047 Reset mid-DATA: rst pulsed while in DATA -> all outputs 0 asynchronously, FSM in IDLE after release, next request restarts from cycle N+1.
